// File: rtl/fifo_fwft_width_down.sv
// Width-down stage: pops wide words from a first-word-fall-through FIFO and
// replays each one as RATIO narrow beats on a valid/ready stream.
module fifo_fwft_width_down #(
    parameter int DATA_WIDTH = 32,
    parameter int RATIO      = 4,
    parameter int LSB_FIRST  = 1,
    parameter int OUT_WIDTH  = DATA_WIDTH / RATIO
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [OUT_WIDTH-1:0]  m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy
);

    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

    logic [DATA_WIDTH-1:0] word_q;
    logic                  word_valid;
    logic [IDX_W-1:0]      idx;

    logic beat_xfer;
    logic word_done;
    logic load;

    assign beat_xfer = word_valid & m_ready;
    assign word_done = beat_xfer & (idx == IDX_LAST);

    // Refill in the same cycle the last beat is accepted so word boundaries
    // cost no bubble; rst_n gates the pop so reset never consumes a word.
    assign load       = rst_n & ~fifo_empty & (~word_valid | word_done);
    assign fifo_rd_en = load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q     <= '0;
            word_valid <= 1'b0;
            idx        <= '0;
        end else if (load) begin
            word_q     <= fifo_dout;
            word_valid <= 1'b1;
            idx        <= '0;
        end else if (word_done) begin
            word_valid <= 1'b0;
            idx        <= '0;
        end else if (beat_xfer) begin
            idx <= idx + IDX_W'(1);
        end
    end

    always_comb begin
        m_data = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (idx == IDX_W'(i)) begin
                m_data = word_q[((LSB_FIRST != 0) ? i : (RATIO - 1 - i)) * OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    assign m_valid = word_valid;
    assign m_last  = word_valid & (idx == IDX_LAST);
    assign busy    = word_valid;

endmodule

// File: tb/tb_fifo_fwft_width_down.sv
// Scoreboard bench for fifo_fwft_width_down: three instances cover LSB-first,
// MSB-first and RATIO=1; a monitor checks every accepted beat against a queue.
module tb_fifo_fwft_width_down;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] dout  [3];
    logic        empty [3];
    logic        rd    [3];
    logic [7:0]  md    [3];
    logic        mv    [3];
    logic        mr    [3];
    logic        ml    [3];
    logic        bz    [3];

    logic [31:0] fq [3][$];
    beat_t       eq [3][$];
    logic        pend [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_fwft_width_down #(.DATA_WIDTH(32), .RATIO(4), .LSB_FIRST(1)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .fifo_dout(dout[0]), .fifo_empty(empty[0]),
        .fifo_rd_en(rd[0]), .m_data(md[0]), .m_valid(mv[0]), .m_ready(mr[0]),
        .m_last(ml[0]), .busy(bz[0]));

    fifo_fwft_width_down #(.DATA_WIDTH(32), .RATIO(4), .LSB_FIRST(0)) dut_msb (
        .clk(clk), .rst_n(rst_n), .fifo_dout(dout[1]), .fifo_empty(empty[1]),
        .fifo_rd_en(rd[1]), .m_data(md[1]), .m_valid(mv[1]), .m_ready(mr[1]),
        .m_last(ml[1]), .busy(bz[1]));

    fifo_fwft_width_down #(.DATA_WIDTH(8), .RATIO(1), .LSB_FIRST(1)) dut_r1 (
        .clk(clk), .rst_n(rst_n), .fifo_dout(dout[2][7:0]), .fifo_empty(empty[2]),
        .fifo_rd_en(rd[2]), .m_data(md[2]), .m_valid(mv[2]), .m_ready(mr[2]),
        .m_last(ml[2]), .busy(bz[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refresh(input int i);
        if (fq[i].size() > 0) begin
            dout[i]  = fq[i][0];
            empty[i] = 1'b0;
        end else begin
            dout[i]  = '0;
            empty[i] = 1'b1;
        end
    endtask

    task automatic push(input int i, input logic [31:0] w);
        fq[i].push_back(w);
        refresh(i);
    endtask

    task automatic expb(input int i, input logic [7:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        eq[i].push_back(b);
    endtask

    task automatic drv();
        @(posedge clk);
        #2;
    endtask

    // FIFO model: the pop strobe seen before the edge retires the head word
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) pend[i] = rd[i];
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            if (pend[i] && fq[i].size() > 0) void'(fq[i].pop_front());
            pend[i] = 1'b0;
            refresh(i);
        end
    end

    // Monitor: every accepted beat must match the head of its expected queue
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_n && mv[i] && mr[i]) begin
                if (eq[i].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat dut=%0d actual=%h required=none", i, md[i]);
                end else begin
                    beat_t b;
                    b = eq[i].pop_front();
                    chk($sformatf("beat_data dut%0d", i), {24'h0, md[i]}, {24'h0, b.d});
                    chk($sformatf("beat_last dut%0d", i), {31'h0, ml[i]}, {31'h0, b.l});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t1 [4];
        logic [7:0] t4 [10];
        logic       p4 [10];
        logic [7:0] t5 [4];

        t1 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        t4 = '{8'hAA, 8'hBB, 8'hBB, 8'hBB, 8'hCC, 8'hCC, 8'hCC, 8'hDD, 8'hDD, 8'hDD};
        p4 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        t5 = '{8'h11, 8'h22, 8'h33, 8'h44};

        for (int i = 0; i < 3; i++) begin
            mr[i]   = 1'b0;
            pend[i] = 1'b0;
            refresh(i);
        end
        mr[0] = 1'b1;

        // Reset state, with a word already waiting in the FIFO
        #2;
        push(0, 32'hDDCCBBAA);
        expb(0, 8'hAA, 0); expb(0, 8'hBB, 0); expb(0, 8'hCC, 0); expb(0, 8'hDD, 1);
        @(negedge clk);
        chk("rst_m_valid", {31'h0, mv[0]}, 0);
        chk("rst_m_last",  {31'h0, ml[0]}, 0);
        chk("rst_m_data",  {24'h0, md[0]}, 0);
        chk("rst_busy",    {31'h0, bz[0]}, 0);
        chk("rst_rd_en",   {31'h0, rd[0]}, 0);

        // Test 1: single word, LSB first, continuous ready
        drv();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_rd_en_pop", {31'h0, rd[0]}, 1);
        chk("t1_valid_before_load", {31'h0, mv[0]}, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t1_valid", {31'h0, mv[0]}, 1);
            chk("t1_data",  {24'h0, md[0]}, {24'h0, t1[k]});
            chk("t1_last",  {31'h0, ml[0]}, (k == 3) ? 1 : 0);
            chk("t1_rd_en", {31'h0, rd[0]}, 0);
        end
        @(negedge clk);
        chk("t1_valid_after", {31'h0, mv[0]}, 0);

        // Test 2: two back-to-back words, no bubble at the boundary
        drv();
        push(0, 32'h03020100);
        push(0, 32'h07060504);
        for (int k = 0; k < 8; k++) expb(0, 8'(k), (k == 3 || k == 7));
        @(negedge clk);
        chk("t2_rd_en_first", {31'h0, rd[0]}, 1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t2_valid", {31'h0, mv[0]}, 1);
            chk("t2_data",  {24'h0, md[0]}, k);
            chk("t2_rd_en", {31'h0, rd[0]}, (k == 3) ? 1 : 0);
        end
        @(negedge clk);
        chk("t2_valid_after", {31'h0, mv[0]}, 0);

        // Test 4: backpressure with a second word queued behind
        drv();
        mr[0] = 1'b0;
        push(0, 32'hDDCCBBAA);
        push(0, 32'h44332211);
        expb(0, 8'hAA, 0); expb(0, 8'hBB, 0); expb(0, 8'hCC, 0); expb(0, 8'hDD, 1);
        expb(0, 8'h11, 0); expb(0, 8'h22, 0); expb(0, 8'h33, 0); expb(0, 8'h44, 1);
        @(negedge clk);
        chk("t4_rd_en_first", {31'h0, rd[0]}, 1);
        for (int c = 0; c < 10; c++) begin
            drv();
            mr[0] = p4[c];
            @(negedge clk);
            chk("t4_valid", {31'h0, mv[0]}, 1);
            chk("t4_data",  {24'h0, md[0]}, {24'h0, t4[c]});
            chk("t4_last",  {31'h0, ml[0]}, (c >= 7) ? 1 : 0);
            chk("t4_rd_en", {31'h0, rd[0]}, (c == 9) ? 1 : 0);
        end
        drv();
        mr[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t4_second_data", {24'h0, md[0]}, {24'h0, t5[k]});
        end
        @(negedge clk);
        chk("t4_valid_after", {31'h0, mv[0]}, 0);

        // Test 5: asynchronous reset after two beats
        drv();
        push(0, 32'hDDCCBBAA);
        expb(0, 8'hAA, 0); expb(0, 8'hBB, 0); expb(0, 8'hCC, 0); expb(0, 8'hDD, 1);
        @(negedge clk);
        chk("t5_rd_en_pop", {31'h0, rd[0]}, 1);
        @(negedge clk);
        chk("t5_beat0", {24'h0, md[0]}, 32'hAA);
        @(negedge clk);
        chk("t5_beat1", {24'h0, md[0]}, 32'hBB);
        @(posedge clk);
        #3;
        push(0, 32'h44332211);
        rst_n = 1'b0;
        eq[0].delete();
        expb(0, 8'h11, 0); expb(0, 8'h22, 0); expb(0, 8'h33, 0); expb(0, 8'h44, 1);
        #1;
        chk("t5_valid_in_reset", {31'h0, mv[0]}, 0);
        chk("t5_busy_in_reset",  {31'h0, bz[0]}, 0);
        chk("t5_rd_en_in_reset", {31'h0, rd[0]}, 0);
        @(negedge clk);
        chk("t5_rd_en_reset_negedge", {31'h0, rd[0]}, 0);
        chk("t5_data_in_reset", {24'h0, md[0]}, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_rd_en_after", {31'h0, rd[0]}, 1);
        chk("t5_valid_before_load", {31'h0, mv[0]}, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t5_data", {24'h0, md[0]}, {24'h0, t5[k]});
        end
        @(negedge clk);
        chk("t5_valid_after", {31'h0, mv[0]}, 0);

        // Test 3: MSB-first slicing
        drv();
        mr[1] = 1'b1;
        push(1, 32'h11223344);
        expb(1, 8'h11, 0); expb(1, 8'h22, 0); expb(1, 8'h33, 0); expb(1, 8'h44, 1);
        @(negedge clk);
        chk("t3_rd_en", {31'h0, rd[1]}, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t3_data", {24'h0, md[1]}, {24'h0, t5[k]});
            chk("t3_last", {31'h0, ml[1]}, (k == 3) ? 1 : 0);
        end
        @(negedge clk);
        chk("t3_valid_after", {31'h0, mv[1]}, 0);

        // Test 6: RATIO=1 registered pass-through
        drv();
        mr[2] = 1'b1;
        push(2, 32'h5A);
        push(2, 32'hA5);
        expb(2, 8'h5A, 1); expb(2, 8'hA5, 1);
        @(negedge clk);
        chk("t6_rd_en_first", {31'h0, rd[2]}, 1);
        chk("t6_valid_latency", {31'h0, mv[2]}, 0);
        @(negedge clk);
        chk("t6_valid0", {31'h0, mv[2]}, 1);
        chk("t6_data0",  {24'h0, md[2]}, 32'h5A);
        chk("t6_last0",  {31'h0, ml[2]}, 1);
        chk("t6_rd_en0", {31'h0, rd[2]}, 1);
        @(negedge clk);
        chk("t6_data1",  {24'h0, md[2]}, 32'hA5);
        chk("t6_last1",  {31'h0, ml[2]}, 1);
        chk("t6_rd_en1", {31'h0, rd[2]}, 0);
        @(negedge clk);
        chk("t6_valid_after", {31'h0, mv[2]}, 0);

        for (int i = 0; i < 3; i++)
            chk($sformatf("expected_drained dut%0d", i), eq[i].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
